// File: rtl/data_array_port_ctrl.sv
// Request/response front end for one OpenRAM-style data array port (read or byte-masked write).
// Optional performance counters are enabled with DATA_ARRAY_CTRL_PERF_EN.
module data_array_port_ctrl #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef DATA_ARRAY_CTRL_PERF_EN
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  accept;
  logic                  latch_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_hold) hold_q <= sram_dout0;
    end
  end

  // req_ready is gated by rst_n so nothing reaches the array while reset is asserted
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = hold_q;
    latch_hold = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
      end
      RD: begin
        req_ready = rst_n & rsp_ready;
        rsp_valid = 1'b1;
        rsp_rdata = sram_dout0;
        if (!rsp_ready) begin
          latch_hold = 1'b1;
          state_d    = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    accept = req_valid & req_ready;
    if (accept && !req_we) state_d = RD;
  end

  assign sram_csb0   = ~accept;
  assign sram_web0   = ~(accept & req_we);
  assign sram_wmask0 = accept ? req_wmask : '0;
  assign sram_addr0  = req_addr;
  assign sram_din0   = req_wdata;

`ifdef DATA_ARRAY_CTRL_PERF_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && !req_we && rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (accept && req_we && wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (rsp_valid && !rsp_ready && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = rd_cnt_q;
  assign perf_wr_cnt    = wr_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_array_port_ctrl.sv
// Directed bench for data_array_port_ctrl with a behavioural 1-cycle-latency SRAM model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_data_array_port_ctrl;
  localparam int DW = 256;
  localparam int NW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [NW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [NW-1:0] sram_wmask0;
  logic [DW-1:0] sram_din0, sram_dout0;
`ifdef DATA_ARRAY_CTRL_PERF_EN
  logic [31:0]   perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] dout_q;
  logic          ovr;
  logic [DW-1:0] ovr_val;

  always #5 clk = ~clk;

  data_array_port_ctrl #(.DATA_WIDTH(DW), .NUM_WMASKS(NW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef DATA_ARRAY_CTRL_PERF_EN
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_wmask0(sram_wmask0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Array model: byte-lane masked write, registered read
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < NW; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end else begin
        dout_q <= mem[sram_addr0];
      end
    end
  end

  assign sram_dout0 = ovr ? ovr_val : dout_q;

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'h1000_0000 + i;
    return {8{w}};
  endfunction

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [NW-1:0] m, input logic [DW-1:0] d, input logic rr);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_wmask = m; req_wdata = d; rsp_ready = rr;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ovr = 1'b0; ovr_val = '0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd1; req_wmask = '1; req_wdata = '1;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: csb0=%b web0=%b req_ready=%b rsp_valid=%b, want 1 1 0 0",
               sram_csb0, sram_web0, req_ready, rsp_valid);
    end
    vec_cnt++;
    if (sram_wmask0 !== '0) begin
      err_cnt++;
      $display("FAIL reset_wmask: got %h, want 0", sram_wmask0);
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    #1;
    vec_cnt++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: req_ready=%b rsp_valid=%b, want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, {8{32'hDEAD_BEEF}}, 1'b1);
    vec_cnt++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== 32'hFFFF_FFFF) begin
      err_cnt++;
      $display("FAIL wr_issue: csb0=%b web0=%b wmask0=%h, want 0 0 ffffffff",
               sram_csb0, sram_web0, sram_wmask0);
    end
    drive(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    vec_cnt++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || rsp_valid !== 1'b0 || sram_addr0 !== 4'd3) begin
      err_cnt++;
      $display("FAIL rd_issue: csb0=%b web0=%b rsp_valid=%b addr0=%0d, want 0 1 0 3",
               sram_csb0, sram_web0, rsp_valid, sram_addr0);
    end
    idle_cycle();
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== {8{32'hDEAD_BEEF}}) begin
      err_cnt++;
      $display("FAIL raw_rdata: valid=%b data=%h, want 1 deadbeef x8", rsp_valid, rsp_rdata);
    end
    idle_cycle();
    vec_cnt++;
    if (rsp_valid !== 1'b0 || sram_csb0 !== 1'b1) begin
      err_cnt++;
      $display("FAIL raw_done: rsp_valid=%b csb0=%b, want 0 1", rsp_valid, sram_csb0);
    end
  endtask

  task automatic test_partial_write();
    drive(1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF, '0, 1'b1);
    drive(1'b1, 1'b1, 4'd5, 32'h0000_0001, 256'hAB, 1'b1);
    // all-zero mask still strobes the array but must not change it
    drive(1'b1, 1'b1, 4'd5, 32'h0000_0000, '1, 1'b1);
    vec_cnt++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_wmask0 !== '0) begin
      err_cnt++;
      $display("FAIL zero_mask_issue: csb0=%b web0=%b wmask0=%h, want 0 0 0",
               sram_csb0, sram_web0, sram_wmask0);
    end
    drive(1'b1, 1'b0, 4'd5, '0, '0, 1'b1);
    idle_cycle();
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 256'hAB) begin
      err_cnt++;
      $display("FAIL partial_rdata: valid=%b data=%h, want 1 ab", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 4'd0, '0, '0, 1'b0);
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== {8{32'hDEAD_BEEF}} || req_ready !== 1'b0 || sram_csb0 !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_rd_cycle: valid=%b rdy=%b csb0=%b data=%h",
               rsp_valid, req_ready, sram_csb0, rsp_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'd0, '0, '0, 1'b0);
      ovr = 1'b1; ovr_val = pat(100 + k);
      #1;
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== {8{32'hDEAD_BEEF}} || req_ready !== 1'b0 || sram_csb0 !== 1'b1) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d]: valid=%b rdy=%b csb0=%b data=%h",
                 k, rsp_valid, req_ready, sram_csb0, rsp_rdata);
      end
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== {8{32'hDEAD_BEEF}} || req_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_release: valid=%b rdy=%b data=%h", rsp_valid, req_ready, rsp_rdata);
    end
    ovr = 1'b0;
    idle_cycle();
    vec_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_idle: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_write_during_rd();
    drive(1'b1, 1'b0, 4'd3, '0, '0, 1'b1);
    drive(1'b1, 1'b1, 4'd7, 32'hFFFF_FFFF, pat(7), 1'b1);
    vec_cnt++;
    if (req_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 ||
        rsp_valid !== 1'b1 || rsp_rdata !== {8{32'hDEAD_BEEF}}) begin
      err_cnt++;
      $display("FAIL wr_in_rd: rdy=%b csb0=%b web0=%b valid=%b data=%h",
               req_ready, sram_csb0, sram_web0, rsp_valid, rsp_rdata);
    end
    idle_cycle();
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_no_rsp: rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, i[AW-1:0], '1, pat(i), 1'b1);
    for (int k = 0; k <= 17; k++) begin
      if (k < 16) drive(1'b1, 1'b0, k[AW-1:0], '0, '0, 1'b1);
      else idle_cycle();
      if (k < 16) begin
        vec_cnt++;
        if (sram_csb0 !== 1'b0 || req_ready !== 1'b1) begin
          err_cnt++;
          $display("FAIL stream_issue[%0d]: csb0=%b req_ready=%b, want 0 1", k, sram_csb0, req_ready);
        end
      end
      if (k >= 1 && k <= 16) begin
        vec_cnt++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat(k - 1)) begin
          err_cnt++;
          $display("FAIL stream_rsp[%0d]: valid=%b data=%h want %h", k - 1, rsp_valid, rsp_rdata, pat(k - 1));
        end
      end
      if (k == 17) begin
        vec_cnt++;
        if (rsp_valid !== 1'b0) begin
          err_cnt++;
          $display("FAIL stream_end: rsp_valid=%b, want 0", rsp_valid);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 4'd2, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_pre: rsp_valid=%b, want 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      err_cnt++;
      $display("FAIL midrst_drop: valid=%b rdy=%b csb0=%b web0=%b, want 0 0 1 1",
               rsp_valid, req_ready, sram_csb0, sram_web0);
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle_cycle();
      vec_cnt++;
      if (rsp_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL midrst_norsp[%0d]: rsp_valid=%b, want 0", k, rsp_valid);
      end
    end
`ifdef DATA_ARRAY_CTRL_PERF_EN
    vec_cnt++;
    if (perf_rd_cnt !== 32'd0 || perf_wr_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      err_cnt++;
      $display("FAIL perf_reset: rd=%0d wr=%0d stall=%0d, want 0 0 0",
               perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    dout_q = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_write_during_rd();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
